// File: rtl/spi_master_txrx.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_txrx
//  Purpose  : Single-byte SPI master in mode 0 (CPOL=0, CPHA=0), MSB first.
//             Accepts a byte on a start/busy/done handshake, drives CS_N,
//             SCLK and MOSI, and returns the byte captured from MISO.
//  Ports    : clk      - system clock, all state changes on posedge
//             reset    - synchronous active-high reset
//             start    - transaction request, honoured only while idle
//             tx_data  - byte to send, latched when start is accepted
//             rx_data  - last complete received byte
//             busy     - transaction in progress
//             done     - one-cycle pulse at transaction end
//             sclk     - SPI clock, idles low
//             mosi     - serial data out, MSB first
//             miso     - serial data in, sampled as SCLK rises
//             cs_n     - active-low chip select
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master_txrx #(
    parameter int CLKDIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);

    generate
        if (CLKDIV < 1) begin : g_bad_clkdiv
            $error("spi_master_txrx: CLKDIV must be >= 1");
        end
    endgenerate

    localparam int            CW        = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [CW-1:0] C_CNT_MAX = CW'(CLKDIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt,   w_cnt;
    logic [3:0]      r_bits,  w_bits;    // bits sampled so far, 0..8
    logic [6:0]      r_tx_sr, w_tx_sr;   // bits still to be sent after MSB
    logic [7:0]      r_rx_sr, w_rx_sr;
    logic [7:0]      r_rx_data, w_rx_data;
    logic            r_busy,  w_busy;
    logic            r_done,  w_done;
    logic            r_sclk,  w_sclk;
    logic            r_mosi,  w_mosi;
    logic            r_cs_n,  w_cs_n;
    logic            w_expire;

    assign w_expire = (r_cnt == C_CNT_MAX);

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_bits    = r_bits;
        w_tx_sr   = r_tx_sr;
        w_rx_sr   = r_rx_sr;
        w_rx_data = r_rx_data;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_sclk    = r_sclk;
        w_mosi    = r_mosi;
        w_cs_n    = r_cs_n;

        // Half-period counter free-runs in every active state and wraps on expiry.
        if (r_state != S_IDLE) begin
            w_cnt = w_expire ? '0 : r_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_cnt  = '0;
                w_bits = 4'd0;
                if (start) begin
                    w_tx_sr = tx_data[6:0];
                    w_mosi  = tx_data[7];
                    w_cs_n  = 1'b0;
                    w_busy  = 1'b1;
                    w_state = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_expire) begin
                    // First rising edge: MSB has been on MOSI for a full half-period.
                    w_sclk  = 1'b1;
                    w_rx_sr = {r_rx_sr[6:0], miso};
                    w_bits  = r_bits + 4'd1;
                    w_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_expire) begin
                    if (r_sclk) begin
                        w_sclk = 1'b0;
                        if (r_bits < 4'd8) begin
                            w_mosi  = r_tx_sr[6];
                            w_tx_sr = {r_tx_sr[5:0], 1'b0};
                        end else begin
                            // Eighth falling edge: MOSI keeps its last bit through HOLD.
                            w_state = S_HOLD;
                        end
                    end else begin
                        w_sclk  = 1'b1;
                        w_rx_sr = {r_rx_sr[6:0], miso};
                        w_bits  = r_bits + 4'd1;
                    end
                end
            end
            S_HOLD: begin
                if (w_expire) begin
                    w_cs_n    = 1'b1;
                    w_busy    = 1'b0;
                    w_done    = 1'b1;
                    w_rx_data = r_rx_sr;
                    w_mosi    = 1'b0;
                    w_cnt     = '0;
                    w_state   = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bits    <= 4'd0;
            r_tx_sr   <= 7'd0;
            r_rx_sr   <= 8'd0;
            r_rx_data <= 8'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_bits    <= w_bits;
            r_tx_sr   <= w_tx_sr;
            r_rx_sr   <= w_rx_sr;
            r_rx_data <= w_rx_data;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_sclk    <= w_sclk;
            r_mosi    <= w_mosi;
            r_cs_n    <= w_cs_n;
        end
    end

    assign rx_data = r_rx_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign sclk    = r_sclk;
    assign mosi    = r_mosi;
    assign cs_n    = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_txrx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master_txrx
//  Purpose  : Self-checking bench for spi_master_txrx. Two instances run with
//             CLKDIV=4 and CLKDIV=1; each has a mode-0 slave model that can
//             either loop MOSI back or shift out a chosen byte.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_txrx;

    logic            clk = 1'b0;
    logic [1:0]      rst_v;
    logic [1:0]      start_v;
    logic [1:0][7:0] tx_v;
    logic [1:0][7:0] rx_v;
    logic [1:0]      busy_v;
    logic [1:0]      done_v;
    logic [1:0]      sclk_v;
    logic [1:0]      mosi_v;
    logic [1:0]      miso_v;
    logic [1:0]      cs_n_v;

    // slave model controls and observations
    logic [1:0]      loop_v;
    logic [1:0][7:0] slv_tx_v;
    logic [1:0][7:0] slv_rx_v;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_rx [2];

    always #5 clk = ~clk;

    spi_master_txrx #(.CLKDIV(4)) u_dut4 (
        .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .tx_data(tx_v[0]),
        .rx_data(rx_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sclk(sclk_v[0]),
        .mosi(mosi_v[0]), .miso(miso_v[0]), .cs_n(cs_n_v[0])
    );

    spi_master_txrx #(.CLKDIV(1)) u_dut1 (
        .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .tx_data(tx_v[1]),
        .rx_data(rx_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sclk(sclk_v[1]),
        .mosi(mosi_v[1]), .miso(miso_v[1]), .cs_n(cs_n_v[1])
    );

    // Mode-0 slave: loads its byte when selected, shifts on SCLK falling,
    // captures MOSI on SCLK rising. Evaluated mid-cycle so MISO is stable at
    // the next clk edge.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slave
        logic [7:0] sh  = 8'd0;
        logic [7:0] rcv = 8'd0;
        logic       p_cs_n = 1'b1;
        logic       p_sclk = 1'b0;
        always @(negedge clk) begin
            if (p_cs_n && !cs_n_v[gi]) begin
                sh  <= slv_tx_v[gi];
                rcv <= 8'd0;
            end else if (p_sclk && !sclk_v[gi]) begin
                sh <= {sh[6:0], 1'b0};
            end else if (!p_sclk && sclk_v[gi]) begin
                rcv <= {rcv[6:0], mosi_v[gi]};
            end
            p_cs_n <= cs_n_v[gi];
            p_sclk <= sclk_v[gi];
        end
        assign miso_v[gi]   = loop_v[gi] ? mosi_v[gi] : sh[7];
        assign slv_rx_v[gi] = rcv;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic idle_check(input int idx, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            chk($sformatf("idle%0d.cs_n", idx), 32'(cs_n_v[idx]), 32'd1);
            chk($sformatf("idle%0d.sclk", idx), 32'(sclk_v[idx]), 32'd0);
            chk($sformatf("idle%0d.mosi", idx), 32'(mosi_v[idx]), 32'd0);
            chk($sformatf("idle%0d.busy", idx), 32'(busy_v[idx]), 32'd0);
            chk($sformatf("idle%0d.done", idx), 32'(done_v[idx]), 32'd0);
            chk($sformatf("idle%0d.rx", idx), 32'(rx_v[idx]), 32'(last_rx[idx]));
        end
    endtask

    // One transaction; returns at the sample showing the done pulse, so a
    // following call asserts start inside the done cycle.
    task automatic run_txn(input int idx, input logic [7:0] tx, input logic [7:0] sbyte,
                           input bit loopb, input bit midstart);
        int         cd;
        int         n;
        int         rises;
        int         low_cnt;
        int         busy_cnt;
        int         bad_sclk;
        int         done_at;
        logic [7:0] mosi_bits;
        logic [7:0] got_rx;
        logic [7:0] exp_rx;
        logic       prev_sclk;
        cd           = (idx == 0) ? 4 : 1;
        exp_rx       = loopb ? tx : sbyte;
        slv_tx_v[idx] = sbyte;
        loop_v[idx]  = loopb;
        start_v[idx] = 1'b1;
        tx_v[idx]    = tx;
        @(negedge clk);
        start_v[idx] = 1'b0;
        tx_v[idx]    = 8'($urandom);
        chk($sformatf("txn%0d.accept_cs_n", idx), 32'(cs_n_v[idx]), 32'd0);
        chk($sformatf("txn%0d.accept_busy", idx), 32'(busy_v[idx]), 32'd1);
        n = 0; rises = 0; low_cnt = 0; busy_cnt = 0; bad_sclk = 0; done_at = -1;
        mosi_bits = 8'd0; got_rx = 8'd0; prev_sclk = 1'b0;
        while (n < 17 * cd + 8) begin
            if (!cs_n_v[idx]) low_cnt++;
            if (busy_v[idx]) busy_cnt++;
            if (cs_n_v[idx] && sclk_v[idx]) bad_sclk++;
            if (sclk_v[idx] && !prev_sclk) begin
                rises++;
                mosi_bits = {mosi_bits[6:0], mosi_v[idx]};
            end
            prev_sclk = sclk_v[idx];
            if (done_v[idx]) begin
                done_at = n;
                got_rx  = rx_v[idx];
                break;
            end
            if (midstart && n == 3 * cd) begin
                start_v[idx] = 1'b1;
                tx_v[idx]    = 8'hFF;
            end else if (midstart && n == 3 * cd + 1) begin
                start_v[idx] = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start_v[idx] = 1'b0;
        chk($sformatf("txn%0d.done_time", idx), 32'(done_at), 32'(17 * cd));
        chk($sformatf("txn%0d.cs_low_cycles", idx), 32'(low_cnt), 32'(17 * cd));
        chk($sformatf("txn%0d.busy_cycles", idx), 32'(busy_cnt), 32'(17 * cd));
        chk($sformatf("txn%0d.sclk_rises", idx), 32'(rises), 32'd8);
        chk($sformatf("txn%0d.sclk_idle_low", idx), 32'(bad_sclk), 32'd0);
        chk($sformatf("txn%0d.mosi_bits", idx), 32'(mosi_bits), 32'(tx));
        chk($sformatf("txn%0d.slave_rx", idx), 32'(slv_rx_v[idx]), 32'(tx));
        chk($sformatf("txn%0d.rx_data", idx), 32'(got_rx), 32'(exp_rx));
        chk($sformatf("txn%0d.end_cs_n", idx), 32'(cs_n_v[idx]), 32'd1);
        chk($sformatf("txn%0d.end_sclk", idx), 32'(sclk_v[idx]), 32'd0);
        chk($sformatf("txn%0d.end_mosi", idx), 32'(mosi_v[idx]), 32'd0);
        if (done_at >= 0) last_rx[idx] = exp_rx;
    endtask

    // Reset after the third SCLK rising edge of a transaction.
    task automatic run_abort(input int idx, input logic [7:0] tx);
        int   n;
        int   rises;
        logic prev_sclk;
        loop_v[idx]  = 1'b1;
        start_v[idx] = 1'b1;
        tx_v[idx]    = tx;
        @(negedge clk);
        start_v[idx] = 1'b0;
        n = 0; rises = 0; prev_sclk = 1'b0;
        while (rises < 3 && n < 200) begin
            if (sclk_v[idx] && !prev_sclk) rises++;
            prev_sclk = sclk_v[idx];
            if (rises < 3) begin
                @(negedge clk);
                n++;
            end
        end
        chk($sformatf("abort%0d.reached_3_rises", idx), 32'(rises), 32'd3);
        rst_v[idx] = 1'b1;
        @(negedge clk);
        rst_v[idx] = 1'b0;
        chk($sformatf("abort%0d.cs_n", idx), 32'(cs_n_v[idx]), 32'd1);
        chk($sformatf("abort%0d.sclk", idx), 32'(sclk_v[idx]), 32'd0);
        chk($sformatf("abort%0d.busy", idx), 32'(busy_v[idx]), 32'd0);
        chk($sformatf("abort%0d.mosi", idx), 32'(mosi_v[idx]), 32'd0);
        chk($sformatf("abort%0d.done", idx), 32'(done_v[idx]), 32'd0);
        // reset clears the output register
        last_rx[idx] = 8'h00;
        chk($sformatf("abort%0d.rx", idx), 32'(rx_v[idx]), 32'(last_rx[idx]));
        idle_check(idx, 5);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t;
        logic [7:0] s;
        rst_v    = 2'b11;
        start_v  = 2'b00;
        tx_v     = '0;
        loop_v   = 2'b11;
        slv_tx_v = '0;
        last_rx[0] = 8'h00;
        last_rx[1] = 8'h00;
        repeat (3) @(negedge clk);
        rst_v = 2'b00;

        for (int idx = 0; idx < 2; idx++) begin
            idle_check(idx, 10);

            run_txn(idx, 8'hA5, 8'h00, 1'b1, 1'b0);
            idle_check(idx, 3);

            run_txn(idx, 8'hC3, 8'h3C, 1'b0, 1'b0);
            idle_check(idx, 3);

            t = 8'($urandom);
            s = 8'($urandom);
            run_txn(idx, t, s, 1'b0, 1'b1);
            idle_check(idx, 3);

            t = 8'($urandom);
            run_txn(idx, t, 8'h00, 1'b1, 1'b0);
            run_txn(idx, 8'h5A, 8'h00, 1'b1, 1'b0);
            idle_check(idx, 3);

            run_abort(idx, 8'($urandom));
            t = 8'($urandom);
            s = 8'($urandom);
            run_txn(idx, t, s, 1'b0, 1'b0);
            idle_check(idx, 2);

            for (int r = 0; r < 4; r++) begin
                t = 8'($urandom);
                s = 8'($urandom);
                run_txn(idx, t, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                idle_check(idx, 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
